// File: rtl/store_rmw_unit_pkg.sv
// Shared store-path definitions: op encodings, store FSM states
// and the alignment rule that the load extender also uses.
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    // Alignment only; reserved encodings are rejected by the caller.
    function automatic logic misaligned(op_e op, logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        unique case (op)
            OP_SW:   bad = (lo != 2'b00);
            OP_SH:   bad = lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request handshake and word-memory port of the store writer.
// master = CPU/memory side, slave = store_rmw_unit.
interface store_rmw_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_op;
    logic              done;
    logic              err;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_addr, req_data, req_op, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_rd_en,
        input  mem_wr_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, mem_rdata,
        output req_ready, done, err, mem_addr, mem_rd_en,
        output mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/store_lane_merge.sv
// Little-endian lane merge of a truncated store value into
// a previously read memory word.
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  op_e         op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        unique case (op)
            OP_SW: merged = new_data;
            OP_SH: begin
                if (addr_lo[1]) merged[31:16] = new_data[15:0];
                else            merged[15:0]  = new_data[15:0];
            end
            OP_SB: merged[{addr_lo, 3'b000} +: 8] = new_data[7:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store-path sub-word writer: SW writes directly, SH/SB do a
// read-modify-write of the addressed memory word.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    store_rmw_unit_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       wdata_q, wdata_d;
    op_e               op_q, op_d;
    logic              err_q, err_d;

    op_e         req_op;
    logic        accept;
    logic        fault;
    logic [31:0] merged;

    assign req_op = op_e'(bus.req_op);
    assign accept = bus.req_valid && bus.req_ready;
    assign fault  = (req_op == OP_RSV)
                 || misaligned(req_op, bus.req_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (fault)                 state_d = S_DONE;
                    else if (req_op == OP_SW) state_d = S_WRITE;
                    else                       state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from state only, so reset drops them at once.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        unique case (state_q)
            S_IDLE:  bus.req_ready = !reset;
            S_READ:  bus.mem_rd_en = 1'b1;
            S_WRITE: bus.mem_wr_en = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

    store_lane_merge u_merge (
        .old_word (bus.mem_rdata),
        .new_data (data_q),
        .op       (op_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (merged)
    );

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d = bus.req_addr;
            data_d = bus.req_data;
            op_d   = req_op;
            err_d  = fault;
            if (!fault && req_op == OP_SW) wdata_d = bus.req_data;
        end
        if (state_q == S_WAIT) wdata_d = merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_SW;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mem_addr  = addr_q[ADDR_W-1:2];
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit with a 16-word memory
// model and a byte-enable reference merge.
module tb_store_rmw_unit;
    import store_rmw_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_rmw_unit_if #(.ADDR_W(32)) bus();

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        err;
        int          lat;
        logic [29:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    exp_t exp_q [$];
    exp_t cur;
    logic inflight = 1'b0;
    logic rdy_pend = 1'b0;
    int hs_p = 0;
    int last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(
        logic [31:0] old, logic [31:0] d, logic [1:0] op, logic [1:0] lo);
        logic [3:0]  be;
        logic [31:0] src;
        logic [31:0] r;
        case (op)
            2'b00: begin be = 4'hF; src = d; end
            2'b01: begin be = lo[1] ? 4'hC : 4'h3; src = {2{d[15:0]}}; end
            default: begin be = 4'b0001 << lo; src = {4{d[7:0]}}; end
        endcase
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? src[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rdy_pend) begin
            rdy_pend = 1'b0;
            if (!reset) chk("rdy_after_done", 32'(bus.req_ready), 1);
        end
        if (bus.req_valid && bus.req_ready && !reset) begin
            if (exp_q.size() == 0) chk("hs_unexp", 1, 0);
            else begin
                cur = exp_q.pop_front();
                inflight = 1'b1;
                hs_p = cyc;
                last_hs = cyc;
            end
        end
        if (bus.mem_rd_en || bus.mem_wr_en)
            chk("rd_wr_excl", 32'(bus.mem_rd_en & bus.mem_wr_en), 0);
        if (bus.mem_rd_en) begin
            if (!inflight || cur.err || cur.lat != 4) chk("rd_unexp", 1, 0);
            else chk("rd_time", 32'(cyc - hs_p), 1);
        end
        if (bus.mem_wr_en) begin
            if (!inflight || cur.err) chk("wr_unexp", 1, 0);
            else begin
                chk("wr_time", 32'(cyc - hs_p), 32'(cur.lat - 1));
                chk("wr_addr", {2'b00, bus.mem_addr}, {2'b00, cur.waddr});
                chk("wr_data", bus.mem_wdata, cur.wdata);
            end
        end
        if (bus.done) begin
            if (!inflight) chk("done_unexp", 1, 0);
            else begin
                chk("done_time", 32'(cyc - hs_p), 32'(cur.lat));
                chk("done_err", 32'(bus.err), 32'(cur.err));
                inflight = 1'b0;
                rdy_pend = 1'b1;
            end
        end else if (bus.err) begin
            chk("err_wo_done", 1, 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input bit keep);
        exp_t e;
        logic f;
        int w;
        f = (op == 2'b11) || (op == 2'b00 && addr[1:0] != 2'b00)
         || (op == 2'b01 && addr[0]);
        e.err   = f;
        e.lat   = f ? 1 : (op == 2'b00 ? 2 : 4);
        e.waddr = addr[31:2];
        e.wdata = f ? 32'h0 : ref_merge(ref_mem[addr[5:2]], data, op, addr[1:0]);
        if (!f) ref_mem[addr[5:2]] = e.wdata;
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_op    = op;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            bus.req_valid = 1'b0;
            bus.req_data  = $urandom;
            bus.req_addr  = $urandom;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((inflight || exp_q.size() > 0) && w < 30) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (inflight || exp_q.size() > 0) chk("idle_timeout", 0, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        logic [1:0] op;
        logic [1:0] lo;
        logic [3:0] wi;
        int a1;
        int a2;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_op    = '0;
        for (int i = 0; i < 16; i++) preload(i, 32'h0101_0101 * i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rd", 32'(bus.mem_rd_en), 0);
        chk("rst_wr", 32'(bus.mem_wr_en), 0);
        chk("rst_maddr", {2'b00, bus.mem_addr}, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        #1;
        chk("rdy_out_of_rst", 32'(bus.req_ready), 1);

        send(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);

        preload(4, 32'h1122_3344);
        send(2'b10, 32'h0000_0013, 32'hFFFF_FFAB, 1'b0);
        wait_idle();
        chk("sb_mem", mem[4], 32'hAB22_3344);

        preload(4, 32'h1122_3344);
        send(2'b01, 32'h0000_0012, 32'h0000_8000, 1'b0);
        wait_idle();
        chk("sh_hi_mem", mem[4], 32'h8000_3344);

        preload(4, 32'h1122_3344);
        send(2'b01, 32'h0000_0010, 32'h0000_8000, 1'b0);
        wait_idle();
        chk("sh_lo_mem", mem[4], 32'h1122_8000);

        send(2'b00, 32'h0000_0002, 32'h1234_5678, 1'b0);
        wait_idle();
        send(2'b01, 32'h0000_0001, 32'h1234_5678, 1'b0);
        wait_idle();
        send(2'b11, 32'h0000_0020, 32'h1234_5678, 1'b0);
        wait_idle();
        chk("err_mem0", mem[0], ref_mem[0]);

        preload(4, 32'h1122_3344);
        send(2'b10, 32'h0000_0013, 32'h0000_00CD, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        inflight = 1'b0;
        #1;
        chk("rst_mid_rd", 32'(bus.mem_rd_en), 0);
        chk("rst_mid_wr", 32'(bus.mem_wr_en), 0);
        chk("rst_mid_done", 32'(bus.done), 0);
        chk("rst_mid_rdy", 32'(bus.req_ready), 0);
        ref_mem[4] = 32'h1122_3344;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rdy_post_rst", 32'(bus.req_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_write", mem[4], 32'h1122_3344);
        send(2'b00, 32'h0000_0014, 32'hCAFE_F00D, 1'b0);
        wait_idle();
        chk("post_rst_sw", mem[5], 32'hCAFE_F00D);

        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 2));
            wi = 4'($urandom_range(0, 15));
            if (op == 2'b00) lo = 2'b00;
            else if (op == 2'b01) lo = {1'($urandom_range(0, 1)), 1'b0};
            else lo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) lo = 2'($urandom_range(0, 3));
            send(op, {26'd0, wi, lo}, $urandom, 1'b0);
            wait_idle();
            chk("rand_mem", mem[wi], ref_mem[wi]);
        end

        send(2'b00, 32'h0000_0020, 32'hAAAA_5555, 1'b1);
        a1 = last_hs;
        send(2'b00, 32'h0000_0024, 32'h5555_AAAA, 1'b0);
        a2 = last_hs;
        wait_idle();
        chk("b2b_gap", 32'(a2 - a1), 3);
        chk("b2b_mem0", mem[8], 32'hAAAA_5555);
        chk("b2b_mem1", mem[9], 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-path sub-word writer for the data memory port, performing the opposite conversion to the immediate/load extender. It accepts a 32-bit register value with a store width (word, halfword, byte) and a byte address, truncates the value to the requested width, and commits it to a word-organised synchronous memory. Sub-word stores use a read-modify-write sequence. The block sits between the CPU store datapath and the data RAM.

## Interface
- ADDR_W, 32: byte address width; word address width is ADDR_W-2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block can accept a request; high only in IDLE and while reset is low.
- req_addr  input  ADDR_W  byte address.
- req_data  input  32  register value; upper bits are ignored for SH/SB (truncation).
- req_op  input  2  00 SW, 01 SH, 10 SB, 11 reserved.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = misaligned or reserved op, no memory write performed.
- mem_addr  output  ADDR_W-2  word address, held from accept until done.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rdata  input  32  read data, valid the cycle after mem_rd_en.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wdata  output  32  full-word write data.

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Address, data and op are latched on acceptance; inputs are ignored afterwards.
- Error check at accept:
  - op=11 → error.
  - SW with addr[1:0]≠0 → error.
  - SH with addr[0]=1 → error.
  - SB is never misaligned.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE → WRITE for a legal SW.
  - IDLE → READ for a legal SH/SB.
  - IDLE → DONE on error.
  - READ (mem_rd_en=1) → WAIT.
  - WAIT: capture mem_rdata into the merge register → WRITE.
  - WRITE (mem_wr_en=1) → DONE.
  - DONE (done=1, err as latched) → IDLE.
- Merge is little-endian:
  - SB places req_data[7:0] at bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - SH places req_data[15:0] at [15:0] when addr[1]=0, or at [31:16] when addr[1]=1.
  - All other bits come from the captured word.
  - SW: mem_wdata = req_data.
- Reset values: state IDLE; done=0, err=0, mem_rd_en=0, mem_wr_en=0; mem_addr=0, mem_wdata=0; req_ready=0 while reset is high.
- Reset mid-operation: the FSM returns to IDLE immediately and strobes drop asynchronously. No partial write is issued after reset deasserts, and the request is lost without a done pulse.
- done/err are registered state outputs. err=0 whenever done=0.

## Timing
- Request accepted at edge T. Latency to the done cycle:
  - SW: mem_wr_en in cycle T+1, done in cycle T+2.
  - SH/SB: mem_rd_en T+1, rdata captured T+2, mem_wr_en T+3, done T+4.
  - Error: done+err in cycle T+1, no memory strobes.
- req_ready rises again in the cycle after DONE. Throughput is therefore one SW per 3 cycles and one sub-word store per 5 cycles.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_wdata is stable while mem_wr_en=1.

## Structure
- Shared package holds:
  - Op encodings: OP_SW=2'b00, OP_SH=2'b01, OP_SB=2'b10, OP_RSV=2'b11.
  - The FSM state enum.
  - The misalignment check as a function, reused by the load extender for load-alignment faults.
- One combinational sub-module: store_lane_merge, with inputs old_word[31:0], new_data[31:0], op, addr_lo[1:0] and output merged[31:0]. The top level holds the FSM, latches and memory strobes.

## Test plan
- SW: addr=0x0000_0010, data=0xDEAD_BEEF → mem_wr_en at T+1 with mem_addr=0x4 and wdata=0xDEAD_BEEF; done=1, err=0 at T+2; no mem_rd_en.
- SB: memory word 0x1122_3344, addr=0x...13, data=0xFFFF_FFAB → read at T+1, write 0xAB22_3344 at T+3, done at T+4.
- SH: memory word 0x1122_3344, addr=0x...12, data=0x0000_8000 → write 0x8000_3344; the same test at addr=0x...10 → write 0x1122_8000.
- Errors: SW at addr=0x...02, SH at addr=0x...01, and op=11 → each gives done=1, err=1 at T+1 with zero memory strobes; req_ready=1 at T+2.
- Reset asserted during WAIT of an SB → mem_rd_en/mem_wr_en=0 immediately and no write after release; req_ready=1 in the first cycle after reset deasserts; a following SW completes normally.
- Back-to-back: req_valid held high across two SW requests → the second is accepted exactly in the cycle after the first done, and both writes appear in order.
